// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the data-memory port arbiter.
// Halfword order is big-endian: the halfword at addr holds bits [31:16],
// the halfword at addr+2 holds bits [15:0].
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        D_BEAT1 = 2'd1,
        D_RTAIL = 2'd2
    } mem_arb_state_t;

    // Byte distance between the two halfword beats of a 32-bit access.
    localparam int unsigned HALF_STEP = 2;

    // Rebuild a word from its beat-0 (high) and beat-1 (low) halfwords.
    function automatic logic [31:0] join_halves(input logic [15:0] hi, input logic [15:0] lo);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares the single 16-bit memory port between instruction fetch and the
// execute/memory stage. Data accesses win unless fetch_turn is set, which a
// completed data access raises so the next contested slot goes to fetch.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [15:0]       if_rdata_o,
    output logic              stall_if_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [31:0]       d_wdata_i,
    output logic              d_gnt_o,
    output logic              d_done_o,
    output logic [31:0]       d_rdata_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_re_o,
    output logic              mem_we_o,
    output logic [15:0]       mem_wdata_o,
    input  logic [15:0]       mem_rdata_i
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(1);

    mem_arb_state_t    r_state;
    mem_arb_state_t    w_state_next;
    logic [15:0]       r_hi;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_we;
    logic              r_fetch_turn;
    logic              r_if_rvalid;

    logic              w_latch;
    logic              w_cap_hi;
    logic              w_set_turn;
    logic [ADDR_W-1:0] w_beat1_addr;

    // Wraps modulo 2^ADDR_W by construction.
    assign w_beat1_addr = r_addr + ADDR_W'(HALF_STEP);

    // Next-state, beat issue and requester handshakes; everything forced to 0 in reset.
    always_comb begin
        w_state_next = r_state;
        w_latch      = 1'b0;
        w_cap_hi     = 1'b0;
        w_set_turn   = 1'b0;
        if_gnt_o     = 1'b0;
        if_rvalid_o  = r_if_rvalid;
        if_rdata_o   = mem_rdata_i;
        stall_if_o   = 1'b0;
        d_gnt_o      = 1'b0;
        d_done_o     = 1'b0;
        d_rdata_o    = '0;
        mem_addr_o   = '0;
        mem_re_o     = 1'b0;
        mem_we_o     = 1'b0;
        mem_wdata_o  = '0;

        unique case (r_state)
            IDLE: begin
                if (d_req_i && !(r_fetch_turn && if_req_i)) begin
                    mem_addr_o   = d_addr_i & ALIGN_MASK;
                    mem_re_o     = ~d_we_i;
                    mem_we_o     = d_we_i;
                    mem_wdata_o  = d_we_i ? d_wdata_i[31:16] : 16'h0000;
                    d_gnt_o      = 1'b1;
                    w_latch      = 1'b1;
                    w_state_next = D_BEAT1;
                end else if (if_req_i) begin
                    mem_addr_o = if_addr_i & ALIGN_MASK;
                    mem_re_o   = 1'b1;
                    if_gnt_o   = 1'b1;
                end
            end
            D_BEAT1: begin
                mem_addr_o  = w_beat1_addr;
                mem_re_o    = ~r_we;
                mem_we_o    = r_we;
                mem_wdata_o = r_we ? r_wdata[15:0] : 16'h0000;
                if (r_we) begin
                    d_done_o     = 1'b1;
                    w_set_turn   = 1'b1;
                    w_state_next = IDLE;
                end else begin
                    w_cap_hi     = 1'b1;
                    w_state_next = D_RTAIL;
                end
            end
            D_RTAIL: begin
                d_done_o     = 1'b1;
                d_rdata_o    = join_halves(r_hi, mem_rdata_i);
                w_set_turn   = 1'b1;
                w_state_next = IDLE;
                // Port is free while the second read returns: only fetch may use it.
                if (if_req_i) begin
                    mem_addr_o = if_addr_i & ALIGN_MASK;
                    mem_re_o   = 1'b1;
                    if_gnt_o   = 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase

        stall_if_o = if_req_i & ~if_gnt_o;

        if (rst_i) begin
            if_gnt_o    = 1'b0;
            if_rvalid_o = 1'b0;
            if_rdata_o  = '0;
            stall_if_o  = 1'b0;
            d_gnt_o     = 1'b0;
            d_done_o    = 1'b0;
            d_rdata_o   = '0;
            mem_addr_o  = '0;
            mem_re_o    = 1'b0;
            mem_we_o    = 1'b0;
            mem_wdata_o = '0;
        end
    end

    // State register, access latches, fairness flag and fetch read-valid.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= IDLE;
            r_hi         <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_we         <= 1'b0;
            r_fetch_turn <= 1'b0;
            r_if_rvalid  <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_if_rvalid <= if_gnt_o;
            if (w_latch) begin
                r_addr  <= d_addr_i & ALIGN_MASK;
                r_wdata <= d_wdata_i;
                r_we    <= d_we_i;
            end
            if (w_cap_hi) begin
                r_hi <= mem_rdata_i;
            end
            // A fetch grant consumes the fetch slot, even in the cycle a load completes.
            if (if_gnt_o) begin
                r_fetch_turn <= 1'b0;
            end else if (w_set_turn) begin
                r_fetch_turn <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected memory beats,
// fetch returns and data completions; negedge monitors pop and compare.
module tb_mem_port_arbiter;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [15:0] wdata;
    } beat_t;

    typedef struct {
        logic [15:0] data;
        int          cyc;
    } fetch_t;

    typedef struct {
        logic        is_load;
        logic [31:0] data;
        int          cyc;
    } done_t;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_gnt_o;
    logic        if_rvalid_o;
    logic [15:0] if_rdata_o;
    logic        stall_if_o;
    logic        d_req_i;
    logic        d_we_i;
    logic [31:0] d_addr_i;
    logic [31:0] d_wdata_i;
    logic        d_gnt_o;
    logic        d_done_o;
    logic [31:0] d_rdata_o;
    logic [31:0] mem_addr_o;
    logic        mem_re_o;
    logic        mem_we_o;
    logic [15:0] mem_wdata_o;
    logic [15:0] mem_rdata_i;

    logic [15:0] mem [0:511];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    beat_t  beat_q[$];
    fetch_t fetch_q[$];
    done_t  done_q[$];

    mem_port_arbiter #(.ADDR_W(32)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_gnt_o    (if_gnt_o),
        .if_rvalid_o (if_rvalid_o),
        .if_rdata_o  (if_rdata_o),
        .stall_if_o  (stall_if_o),
        .d_req_i     (d_req_i),
        .d_we_i      (d_we_i),
        .d_addr_i    (d_addr_i),
        .d_wdata_i   (d_wdata_i),
        .d_gnt_o     (d_gnt_o),
        .d_done_o    (d_done_o),
        .d_rdata_o   (d_rdata_o),
        .mem_addr_o  (mem_addr_o),
        .mem_re_o    (mem_re_o),
        .mem_we_o    (mem_we_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous memory model, 1-cycle read latency, indexed by address bits [9:1].
    always @(posedge clk) begin
        if (mem_we_o) mem[mem_addr_o[9:1]] <= mem_wdata_o;
        if (mem_re_o) mem_rdata_i <= mem[mem_addr_o[9:1]];
    end

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void unexpected(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: DUT event with empty scoreboard (cycle %0d)", name, cyc);
    endfunction

    function automatic void check_all_zero(input string name);
        check(name, {31'b0, |{if_gnt_o, if_rvalid_o, if_rdata_o, stall_if_o, d_gnt_o, d_done_o,
                              d_rdata_o, mem_addr_o, mem_re_o, mem_we_o, mem_wdata_o}}, 32'd0);
    endfunction

    // Beat monitor.
    always @(negedge clk) begin : mon_beat
        beat_t b;
        if (mem_re_o || mem_we_o) begin
            if (beat_q.size() == 0) begin
                unexpected("beat");
            end else begin
                b = beat_q.pop_front();
                check("beat_we", {31'b0, mem_we_o}, {31'b0, b.we});
                check("beat_re", {31'b0, mem_re_o}, {31'b0, ~b.we});
                check("beat_addr", mem_addr_o, b.addr);
                check("beat_wdata", {16'b0, mem_wdata_o}, {16'b0, b.wdata});
            end
        end
    end

    // Fetch return monitor.
    always @(negedge clk) begin : mon_fetch
        fetch_t f;
        if (if_rvalid_o) begin
            if (fetch_q.size() == 0) begin
                unexpected("fetch_rvalid");
            end else begin
                f = fetch_q.pop_front();
                check("fetch_rdata", {16'b0, if_rdata_o}, {16'b0, f.data});
                check("fetch_cycle", cyc, f.cyc);
            end
        end
    end

    // Data completion monitor.
    always @(negedge clk) begin : mon_done
        done_t d;
        if (d_done_o) begin
            if (done_q.size() == 0) begin
                unexpected("d_done");
            end else begin
                d = done_q.pop_front();
                if (d.is_load) check("load_rdata", d_rdata_o, d.data);
                check("done_cycle", cyc, d.cyc);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_fetch(input logic [31:0] addr, input logic [15:0] exp);
        next_cycle();
        if_req_i  = 1'b1;
        if_addr_i = addr;
        beat_q.push_back('{1'b0, addr, 16'h0000});
        fetch_q.push_back('{exp, cyc + 1});
        @(negedge clk);
        check("fetch_gnt", {31'b0, if_gnt_o}, 32'd1);
        next_cycle();
        if_req_i = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int c0;
        logic exp_if_gnt [0:5];
        logic exp_d_gnt [0:5];
        logic exp_stall [0:5];
        exp_if_gnt = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        exp_d_gnt  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        exp_stall  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

        rst_i       = 1'b1;
        if_req_i    = 1'b0;
        if_addr_i   = '0;
        d_req_i     = 1'b0;
        d_we_i      = 1'b0;
        d_addr_i    = '0;
        d_wdata_i   = '0;
        mem_rdata_i = '0;
        for (int i = 0; i < 512; i++) mem[i] = 16'h0000;
        mem[9'h080] = 16'hBEEF;  // 0x100
        mem[9'h082] = 16'h0A0B;  // 0x104
        mem[9'h100] = 16'h1234;  // 0x200
        mem[9'h101] = 16'h5678;  // 0x202

        // Reset with requests pending: every output must stay 0.
        next_cycle();
        next_cycle();
        if_req_i  = 1'b1;
        d_req_i   = 1'b1;
        d_we_i    = 1'b1;
        d_addr_i  = 32'h0000_0300;
        d_wdata_i = 32'hFFFF_FFFF;
        @(negedge clk);
        check_all_zero("reset_outputs");
        next_cycle();
        rst_i    = 1'b0;
        if_req_i = 1'b0;
        d_req_i  = 1'b0;
        d_we_i   = 1'b0;
        @(negedge clk);
        check("post_reset_rvalid", {31'b0, if_rvalid_o}, 32'd0);
        check("post_reset_bus", {31'b0, mem_re_o | mem_we_o}, 32'd0);

        // Single fetch.
        do_fetch(32'h0000_0100, 16'hBEEF);

        // Load 0x200; address/we changed after grant must be ignored.
        next_cycle();
        d_req_i  = 1'b1;
        d_we_i   = 1'b0;
        d_addr_i = 32'h0000_0200;
        beat_q.push_back('{1'b0, 32'h0000_0200, 16'h0000});
        beat_q.push_back('{1'b0, 32'h0000_0202, 16'h0000});
        done_q.push_back('{1'b1, 32'h1234_5678, cyc + 2});
        @(negedge clk);
        check("load_gnt", {31'b0, d_gnt_o}, 32'd1);
        next_cycle();
        d_addr_i = 32'hDEAD_0000;
        d_we_i   = 1'b1;
        @(negedge clk);
        check("load_beat1_no_gnt", {31'b0, d_gnt_o}, 32'd0);
        next_cycle();
        next_cycle();
        d_req_i = 1'b0;
        d_we_i  = 1'b0;

        // Store 0xAABBCCDD to 0x300, then read back the low halfword.
        next_cycle();
        d_req_i   = 1'b1;
        d_we_i    = 1'b1;
        d_addr_i  = 32'h0000_0300;
        d_wdata_i = 32'hAABB_CCDD;
        beat_q.push_back('{1'b1, 32'h0000_0300, 16'hAABB});
        beat_q.push_back('{1'b1, 32'h0000_0302, 16'hCCDD});
        done_q.push_back('{1'b0, 32'h0, cyc + 1});
        @(negedge clk);
        check("store_gnt", {31'b0, d_gnt_o}, 32'd1);
        next_cycle();
        d_addr_i  = 32'h0000_0500;
        d_wdata_i = 32'h0;
        next_cycle();
        d_req_i = 1'b0;
        d_we_i  = 1'b0;
        do_fetch(32'h0000_0302, 16'hCCDD);

        // Contention: loads and fetches both held high.
        next_cycle();
        c0        = cyc;
        d_req_i   = 1'b1;
        d_we_i    = 1'b0;
        d_addr_i  = 32'h0000_0200;
        if_req_i  = 1'b1;
        if_addr_i = 32'h0000_0104;
        for (int k = 0; k < 2; k++) begin
            beat_q.push_back('{1'b0, 32'h0000_0200, 16'h0000});
            beat_q.push_back('{1'b0, 32'h0000_0202, 16'h0000});
            beat_q.push_back('{1'b0, 32'h0000_0104, 16'h0000});
            done_q.push_back('{1'b1, 32'h1234_5678, c0 + 2 + 3 * k});
            fetch_q.push_back('{16'h0A0B, c0 + 3 + 3 * k});
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("cont_if_gnt", {31'b0, if_gnt_o}, {31'b0, exp_if_gnt[i]});
            check("cont_d_gnt", {31'b0, d_gnt_o}, {31'b0, exp_d_gnt[i]});
            check("cont_stall", {31'b0, stall_if_o}, {31'b0, exp_stall[i]});
            if (i == 2 || i == 5) check("rtail_done_with_fetch", {31'b0, d_done_o}, 32'd1);
            next_cycle();
        end
        d_req_i  = 1'b0;
        if_req_i = 1'b0;

        // Store at the top of the address space: beat 1 wraps to 0.
        next_cycle();
        d_req_i   = 1'b1;
        d_we_i    = 1'b1;
        d_addr_i  = 32'hFFFF_FFFE;
        d_wdata_i = 32'h1111_2222;
        beat_q.push_back('{1'b1, 32'hFFFF_FFFE, 16'h1111});
        beat_q.push_back('{1'b1, 32'h0000_0000, 16'h2222});
        done_q.push_back('{1'b0, 32'h0, cyc + 1});
        next_cycle();
        next_cycle();
        d_req_i = 1'b0;
        d_we_i  = 1'b0;
        do_fetch(32'h0000_0000, 16'h2222);

        // Reset during D_BEAT1: no second beat, no done, IDLE on release.
        next_cycle();
        d_req_i  = 1'b1;
        d_we_i   = 1'b0;
        d_addr_i = 32'h0000_0200;
        beat_q.push_back('{1'b0, 32'h0000_0200, 16'h0000});
        @(negedge clk);
        check("abort_gnt", {31'b0, d_gnt_o}, 32'd1);
        next_cycle();
        rst_i   = 1'b1;
        d_req_i = 1'b0;
        @(negedge clk);
        check_all_zero("abort_reset_outputs");
        next_cycle();
        rst_i     = 1'b0;
        if_req_i  = 1'b1;
        if_addr_i = 32'h0000_0100;
        beat_q.push_back('{1'b0, 32'h0000_0100, 16'h0000});
        fetch_q.push_back('{16'hBEEF, cyc + 1});
        @(negedge clk);
        check("abort_idle_fetch_gnt", {31'b0, if_gnt_o}, 32'd1);
        check("abort_no_done", {31'b0, d_done_o}, 32'd0);
        next_cycle();
        if_req_i = 1'b0;

        repeat (4) next_cycle();
        check("beat_q_empty", beat_q.size(), 32'd0);
        check("fetch_q_empty", fetch_q.size(), 32'd0);
        check("done_q_empty", done_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequences and shares the single 16-bit data-memory port between instruction fetch (single-halfword reads) and the execute/memory stage (32-bit loads/stores split into two halfword beats). Sits between the fetch stage, the execute/memory stage and the synchronous memory. Data accesses have priority, with a one-slot fairness rule that prevents fetch starvation. Requesters receive grant, valid and done signals, so they no longer compute beat addresses or beat sequencing themselves.

## Interface
- ADDR_W, 32, byte address width

- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous, active-high reset
- if_req_i  in  1  fetch wants one halfword
- if_addr_i  in  ADDR_W  fetch byte address; bit 0 ignored
- if_gnt_o  out  1  fetch beat issued to memory this cycle
- if_rvalid_o  out  1  registered; if_rdata_o valid this cycle
- if_rdata_o  out  16  combinational pass-through of mem_rdata_i
- stall_if_o  out  1  if_req_i & ~if_gnt_o
- d_req_i  in  1  data access request; held until d_done_o
- d_we_i  in  1  1 = store, 0 = load
- d_addr_i  in  ADDR_W  byte address; bit 0 must be 0
- d_wdata_i  in  32  store data
- d_gnt_o  out  1  beat 0 issued this cycle
- d_done_o  out  1  one-cycle pulse; access complete
- d_rdata_o  out  32  load data, valid only when d_done_o & ~we
- mem_addr_o  out  ADDR_W  halfword address; bit 0 always 0
- mem_re_o  out  1  read strobe; data appears on mem_rdata_i next cycle
- mem_we_o  out  1  write strobe; written at the clock edge
- mem_wdata_o  out  16  write halfword
- mem_rdata_i  in  16  read data, 1-cycle latency

## Operation
- **Halfword order:** big-endian. addr holds [31:16]; addr+2 holds [15:0].
- Beat 0 always goes to addr, beat 1 to addr+2, for loads and stores alike.
- addr+2 wraps modulo 2^ADDR_W.
- **Latched at grant:** d_we_i, d_addr_i and d_wdata_i are captured at d_gnt_o. Later changes to these inputs are ignored.

FSM states: IDLE, D_BEAT1, D_RTAIL.
- **IDLE**
  - If d_req_i and not (fetch_turn & if_req_i): issue beat 0 (mem_addr_o=d_addr_i, re or we, mem_wdata_o=d_wdata_i[31:16]), assert d_gnt_o, go to D_BEAT1.
  - Else if if_req_i: issue fetch read, assert if_gnt_o, stay in IDLE.
- **D_BEAT1**
  - Issue beat 1 at latched addr+2, with mem_wdata_o=wdata_q[15:0].
  - Load: capture mem_rdata_i into hi_q, go to D_RTAIL.
  - Store: assert d_done_o, set fetch_turn, go to IDLE.
- **D_RTAIL**
  - Assert d_done_o with d_rdata_o={hi_q, mem_rdata_i}, and set fetch_turn.
  - The port is free this cycle: a fetch may issue (if_gnt_o), but never a data beat. Go to IDLE.
- **fetch_turn:** cleared whenever if_gnt_o is asserted.
- **if_rvalid_o:** register, set to 1 the cycle after any if_gnt_o and 0 otherwise.
- **Bus idle values:** mem_re_o and mem_we_o are 0 in any cycle with no issue. mem_wdata_o is 0 when mem_we_o=0.

## Timing
- **Reset:** while rst_i is high, all outputs are 0. The first cycle after reset has state IDLE, if_rvalid_o=0, hi_q=0, fetch_turn=0.
- **Fetch latency:** if_gnt_o at T gives if_rvalid_o at T+1.
- **Load:** gnt at T, beat 1 at T+1, d_done_o at T+2 (3 cycles).
- **Store:** gnt at T, d_done_o at T+1 (2 cycles).
- **Requester handshake:** after d_done_o, the requester drops d_req_i or presents a new request in the next cycle. d_req_i is never sampled outside IDLE.
- **Reset mid-access:** the partial access is abandoned. No d_done_o, and no further beats. A store may leave only beat 0 written.
- **Simultaneous requests in IDLE:** data wins unless fetch_turn=1.

## Structure
- The shared CPU package holds:
  - the enum mem_arb_state_t {IDLE, D_BEAT1, D_RTAIL}
  - the constant HALF_STEP=2
  - the halfword-order convention
- No sub-module: one FSM plus registers hi_q, addr_q, wdata_q, we_q, fetch_turn and if_rvalid_o.

## Test plan
- **Reset then single fetch:** if_addr_i=0x100 -> mem_addr_o=0x100 with re at T; if_rvalid_o=1 with if_rdata_o equal to the memory content at T+1.
- **Load:** 0x200 preloaded with 0x1234, 0x202 with 0x5678 -> d_done_o at T+2 with d_rdata_o=0x12345678.
- **Store:** 0xAABBCCDD to 0x300 -> beats 0x300/0xAABB then 0x302/0xCCDD; d_done_o at T+1.
- **Contention:** if_req_i and d_req_i high continuously -> grant order data, fetch, data, fetch; stall_if_o high on every data-issue cycle.
- **Fetch in D_RTAIL:** a load and a fetch pending -> if_gnt_o asserted in the same cycle as d_done_o.
- **Edge cases:**
  - Store to 0xFFFFFFFE -> beat 1 address 0x00000000.
  - Reset asserted in D_BEAT1 -> no d_done_o, and IDLE on release.
